// File: rtl/msx_ppi_io.sv
// MSX1 8255 PPI responder (mode 0 only) decoded at BASE..BASE+3, plus the Z80 M1 wait-state generator.
// Port A = slot select (out), port B = keyboard columns (in), port C = keyboard row / cassette / LED / click (out).
`timescale 1ns/1ps
module msx_ppi_io #(
    parameter logic [7:0]  BASE     = 8'hA8,
    parameter int unsigned M1_WAITS = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce_3m58_p,
    input  logic       ce_3m58_n,
    input  logic [7:0] addr,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       m1_n,
    output logic       wait_n,
    input  logic [7:0] kb_col,
    output logic [7:0] slot_sel,
    output logic [3:0] kb_row,
    output logic       cas_motor_n,
    output logic       cas_out,
    output logic       cap_led_n,
    output logic       click
);

    localparam logic [1:0] WAIT_LOAD = 2'(M1_WAITS);

    // Bit set/reset command: C[cmd[3:1]] <= cmd[0], all other bits kept.
    function automatic logic [7:0] bsr_apply(input logic [7:0] port_c, input logic [7:0] cmd);
        logic [7:0] v;
        v = port_c;
        v[cmd[3:1]] = cmd[0];
        return v;
    endfunction

    logic [7:0] r_port_a;
    logic [7:0] r_port_c;
    logic [7:0] r_kb_latch;
    logic       r_wr_done;
    logic       r_rd_latched;
    logic       r_m1_prev;
    logic [1:0] r_wait_cnt;

    logic       w_match;
    logic       w_io_wr;
    logic       w_io_rd;
    logic       w_wr_accept;
    logic       w_rd_capture;
    logic       w_m1_fall;
    logic [7:0] w_port_a_nxt;
    logic [7:0] w_port_c_nxt;
    logic [7:0] w_d_out;
    logic       w_unused_ce_n;

    assign w_unused_ce_n = ce_3m58_n;

    assign w_match      = (addr[7:2] == BASE[7:2]);
    // m1_n must be high: an interrupt acknowledge also drops iorq_n but is not a port access.
    assign w_io_wr      = ~iorq_n & ~wr_n & m1_n & w_match;
    assign w_io_rd      = ~iorq_n & ~rd_n & m1_n & w_match;
    assign w_wr_accept  = ce_3m58_p & w_io_wr & ~r_wr_done;
    assign w_rd_capture = ce_3m58_p & w_io_rd & ~r_rd_latched;
    assign w_m1_fall    = ce_3m58_p & ~m1_n & r_m1_prev;

    // Next value of the output ports for an accepted write.
    always_comb begin
        w_port_a_nxt = r_port_a;
        w_port_c_nxt = r_port_c;
        if (w_wr_accept) begin
            case (addr[1:0])
                2'b00: w_port_a_nxt = d_in;
                2'b01: w_port_a_nxt = r_port_a;
                2'b10: w_port_c_nxt = d_in;
                2'b11: begin
                    if (d_in[7]) begin
                        w_port_a_nxt = 8'h00;
                        w_port_c_nxt = 8'h00;
                    end else begin
                        w_port_c_nxt = bsr_apply(r_port_c, d_in);
                    end
                end
                default: w_port_a_nxt = r_port_a;
            endcase
        end else begin
            w_port_c_nxt = r_port_c;
        end
    end

    // Port registers plus the one-shot flags that make each bus cycle act only once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_port_a     <= 8'h00;
            r_port_c     <= 8'h00;
            r_kb_latch   <= 8'hFF;
            r_wr_done    <= 1'b0;
            r_rd_latched <= 1'b0;
        end else begin
            r_port_a <= w_port_a_nxt;
            r_port_c <= w_port_c_nxt;
            if (iorq_n) begin
                r_wr_done <= 1'b0;
            end else if (w_wr_accept) begin
                r_wr_done <= 1'b1;
            end else begin
                r_wr_done <= r_wr_done;
            end
            if (iorq_n) begin
                r_rd_latched <= 1'b0;
            end else if (w_rd_capture) begin
                r_rd_latched <= 1'b1;
                r_kb_latch   <= kb_col;
            end else begin
                r_rd_latched <= r_rd_latched;
            end
        end
    end

    // M1 edge detect and wait counter; the counter is nonzero exactly while WAIT is asserted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m1_prev  <= 1'b1;
            r_wait_cnt <= 2'd0;
        end else if (ce_3m58_p) begin
            r_m1_prev <= m1_n;
            if (w_m1_fall) begin
                r_wait_cnt <= WAIT_LOAD;
            end else if (r_wait_cnt != 2'd0) begin
                r_wait_cnt <= r_wait_cnt - 2'd1;
            end else begin
                r_wait_cnt <= r_wait_cnt;
            end
        end else begin
            r_m1_prev  <= r_m1_prev;
            r_wait_cnt <= r_wait_cnt;
        end
    end

    // Read data mux; the bus idles at FFh whenever this block is not driving.
    always_comb begin
        w_d_out = 8'hFF;
        if (w_io_rd) begin
            case (addr[1:0])
                2'b00:   w_d_out = r_port_a;
                2'b01:   w_d_out = r_kb_latch;
                2'b10:   w_d_out = r_port_c;
                2'b11:   w_d_out = 8'hFF;
                default: w_d_out = 8'hFF;
            endcase
        end else begin
            w_d_out = 8'hFF;
        end
    end

    assign d_out       = w_d_out;
    assign d_oe        = w_io_rd;
    assign wait_n      = (r_wait_cnt == 2'd0);
    assign slot_sel    = r_port_a;
    assign kb_row      = r_port_c[3:0];
    assign cas_motor_n = r_port_c[4];
    assign cas_out     = r_port_c[5];
    assign cap_led_n   = r_port_c[6];
    assign click       = r_port_c[7];

endmodule

// File: tb/tb_msx_ppi_io.sv
// Randomized bus-transaction bench for msx_ppi_io against a transaction-level PPI model.
// Three instances share the bus so that M1_WAITS = 0, 1 and 2 are all observed.
`timescale 1ns/1ps
module tb_msx_ppi_io;

    logic       clk;
    logic       reset_n, ce_p, ce_n;
    logic [7:0] addr, d_in, kb_col;
    logic       iorq_n, rd_n, wr_n, m1_n;

    logic [7:0] d_out1, d_out2, d_out0, slot1, slot2, slot0;
    logic       d_oe1, d_oe2, d_oe0, wait1, wait2, wait0;
    logic [3:0] row1, row2, row0;
    logic       mot1, mot2, mot0, cout1, cout2, cout0, led1, led2, led0, clk1, clk2, clk0;

    int         n_vec, n_err, cyc, m1_c0;
    bit         chk_en;
    logic [7:0] m_a, m_c, m_kb;
    logic [7:0] rd_first, rd_last;

    msx_ppi_io #(.BASE(8'hA8), .M1_WAITS(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .ce_3m58_p(ce_p), .ce_3m58_n(ce_n), .addr(addr), .d_in(d_in),
        .d_out(d_out1), .d_oe(d_oe1), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
        .wait_n(wait1), .kb_col(kb_col), .slot_sel(slot1), .kb_row(row1), .cas_motor_n(mot1),
        .cas_out(cout1), .cap_led_n(led1), .click(clk1));
    msx_ppi_io #(.BASE(8'hA8), .M1_WAITS(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .ce_3m58_p(ce_p), .ce_3m58_n(ce_n), .addr(addr), .d_in(d_in),
        .d_out(d_out2), .d_oe(d_oe2), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
        .wait_n(wait2), .kb_col(kb_col), .slot_sel(slot2), .kb_row(row2), .cas_motor_n(mot2),
        .cas_out(cout2), .cap_led_n(led2), .click(clk2));
    msx_ppi_io #(.BASE(8'hA8), .M1_WAITS(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .ce_3m58_p(ce_p), .ce_3m58_n(ce_n), .addr(addr), .d_in(d_in),
        .d_out(d_out0), .d_oe(d_oe0), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
        .wait_n(wait0), .kb_col(kb_col), .slot_sel(slot0), .kb_row(row0), .cas_motor_n(mot0),
        .cas_out(cout0), .cap_led_n(led0), .click(clk0));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ce_p is high for the clock edges where cyc becomes a multiple of 4.
    initial begin
        cyc  = 0;
        ce_p = 1'b0;
        ce_n = 1'b0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            ce_p = ((cyc % 4) == 3);
            ce_n = ((cyc % 4) == 1);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic is_rd();
        return !iorq_n && !rd_n && m1_n && (addr >= 8'hA8) && (addr <= 8'hAB);
    endfunction

    function automatic logic [7:0] exp_dout();
        if (!is_rd()) return 8'hFF;
        case (addr - 8'hA8)
            8'd0:    return m_a;
            8'd1:    return m_kb;
            8'd2:    return m_c;
            default: return 8'hFF;
        endcase
    endfunction

    // WAIT is low during the 4*n clocks following the ce edge that saw M1 fall.
    function automatic logic exp_wait(input int n);
        return !(n > 0 && cyc >= m1_c0 && cyc < m1_c0 + 4 * n);
    endfunction

    task automatic m_reset();
        m_a   = 8'h00;
        m_c   = 8'h00;
        m_kb  = 8'hFF;
        m1_c0 = -1000;
    endtask

    task automatic m_write(input logic [7:0] a, input logic [7:0] d);
        if (a >= 8'hA8 && a <= 8'hAB) begin
            case (a - 8'hA8)
                8'd0: m_a = d;
                8'd2: m_c = d;
                8'd3: begin
                    if (d[7]) begin
                        m_a = 8'h00;
                        m_c = 8'h00;
                    end else if (d[0]) begin
                        m_c = m_c | (8'd1 << (d / 8'd2 % 8'd8));
                    end else begin
                        m_c = m_c & ~(8'd1 << (d / 8'd2 % 8'd8));
                    end
                end
                default: ;
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("slot_sel", slot1, m_a);
            chk("port_c_outs", {clk1, led1, cout1, mot1, row1}, m_c);
            chk("d_oe", {7'd0, d_oe1}, {7'd0, is_rd()});
            chk("d_out", d_out1, exp_dout());
            chk("wait_n_w1", {7'd0, wait1}, {7'd0, exp_wait(1)});
            chk("wait_n_w2", {7'd0, wait2}, {7'd0, exp_wait(2)});
            chk("wait_n_w0", {7'd0, wait0}, {7'd0, exp_wait(0)});
            chk("slot_sel_w2", slot2, m_a);
            chk("port_c_w2", {clk2, led2, cout2, mot2, row2}, m_c);
            chk("d_out_w2", d_out2, exp_dout());
            chk("slot_sel_w0", slot0, m_a);
            chk("port_c_w0", {clk0, led0, cout0, mot0, row0}, m_c);
            chk("d_out_w0", d_out0, exp_dout());
            chk("d_oe_w20", {6'd0, d_oe2, d_oe0}, {6'd0, is_rd(), is_rd()});
        end
    end

    task automatic wait_ce();
        logic got;
        got = 1'b0;
        while (!got) begin
            @(posedge clk);
            got = ce_p;
        end
        #1;
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d, input int nce, input bit perturb);
        addr   = a;
        d_in   = d;
        iorq_n = 1'b0;
        wr_n   = 1'b0;
        wait_ce();
        m_write(a, d);
        if (perturb) d_in = ~d;
        repeat (nce - 1) wait_ce();
        iorq_n = 1'b1;
        wr_n   = 1'b1;
        wait_ce();
    endtask

    task automatic io_read(input logic [7:0] a, input int nce, input bit chg, input logic [7:0] newcol,
                           output logic [7:0] first, output logic [7:0] last);
        addr   = a;
        iorq_n = 1'b0;
        rd_n   = 1'b0;
        wait_ce();
        if (a >= 8'hA8 && a <= 8'hAB) m_kb = kb_col;
        @(negedge clk);
        first = d_out1;
        #1;
        if (chg) kb_col = newcol;
        repeat (nce - 1) wait_ce();
        @(negedge clk);
        last = d_out1;
        #1;
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        wait_ce();
    endtask

    task automatic fetch();
        logic [7:0] l1, l2, l0;
        l1 = 8'd0;
        l2 = 8'd0;
        l0 = 8'd0;
        m1_n  = 1'b0;
        rd_n  = 1'b0;
        m1_c0 = ((cyc / 4) + 1) * 4;
        repeat (16) begin
            @(negedge clk);
            l1 = l1 + {7'd0, ~wait1};
            l2 = l2 + {7'd0, ~wait2};
            l0 = l0 + {7'd0, ~wait0};
        end
        #1;
        m1_n = 1'b1;
        rd_n = 1'b1;
        wait_ce();
        wait_ce();
        chk("wait_len_1", l1, 8'd4);
        chk("wait_len_2", l2, 8'd8);
        chk("wait_len_0", l0, 8'd0);
    endtask

    task automatic inta(input logic [7:0] a, input logic [7:0] d, input int strobe);
        addr   = a;
        d_in   = d;
        m1_n   = 1'b0;
        iorq_n = 1'b0;
        if (strobe == 1) rd_n = 1'b0;
        if (strobe == 2) wr_n = 1'b0;
        m1_c0 = ((cyc / 4) + 1) * 4;
        wait_ce();
        wait_ce();
        @(negedge clk);
        chk("inta_d_oe", {7'd0, d_oe1}, 8'd0);
        #1;
        m1_n   = 1'b1;
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        wait_ce();
        wait_ce();
    endtask

    initial begin
        logic [7:0] a;
        int op;
        n_vec   = 0;
        n_err   = 0;
        chk_en  = 1'b0;
        reset_n = 1'b1;
        iorq_n  = 1'b1;
        rd_n    = 1'b1;
        wr_n    = 1'b1;
        m1_n    = 1'b1;
        addr    = 8'h00;
        d_in    = 8'h00;
        kb_col  = 8'hFF;
        m_reset();
        #1;
        reset_n = 1'b0;
        #2;
        chk_en = 1'b1;
        chk("rst_slot_sel", slot1, 8'h00);
        chk("rst_kb_row", {4'd0, row1}, 8'h00);
        chk("rst_click", {7'd0, clk1}, 8'h00);
        chk("rst_wait_n", {7'd0, wait1}, 8'h01);
        chk("rst_d_oe", {7'd0, d_oe1}, 8'h00);
        chk("rst_d_out", d_out1, 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_ce();

        io_write(8'hA8, 8'hA5, 4, 1'b1);
        chk("out_a8_a5", slot1, 8'hA5);
        io_write(8'hAA, 8'h4A, 1, 1'b0);
        chk("out_aa_kb_row", {4'd0, row1}, 8'h0A);
        chk("out_aa_leds", {5'd0, led1, cout1, clk1}, 8'h04);
        io_write(8'hAB, 8'h0F, 2, 1'b0);
        chk("bsr_click_set", {7'd0, clk1}, 8'h01);
        io_write(8'hAB, 8'h0E, 1, 1'b0);
        chk("bsr_click_clr", {7'd0, clk1}, 8'h00);
        io_write(8'hA8, 8'hFF, 1, 1'b0);
        io_write(8'hAB, 8'h82, 1, 1'b0);
        chk("mode_set_a", slot1, 8'h00);
        chk("mode_set_c", {clk1, led1, cout1, mot1, row1}, 8'h00);

        kb_col = 8'hFE;
        io_read(8'hA9, 3, 1'b1, 8'h7F, rd_first, rd_last);
        chk("in_a9_first", rd_first, 8'hFE);
        chk("in_a9_hold", rd_last, 8'hFE);
        io_read(8'hAB, 1, 1'b0, 8'h00, rd_first, rd_last);
        chk("in_ab", rd_first, 8'hFF);
        io_write(8'hA8, 8'h5C, 1, 1'b0);
        io_read(8'hA8, 1, 1'b0, 8'h00, rd_first, rd_last);
        chk("in_a8", rd_first, 8'h5C);

        fetch();
        inta(8'hA8, 8'h33, 2);
        chk("inta_no_write", slot1, 8'h5C);

        addr   = 8'hA8;
        d_in   = 8'h3C;
        iorq_n = 1'b0;
        wr_n   = 1'b0;
        wait_ce();
        m_write(8'hA8, 8'h3C);
        reset_n = 1'b0;
        m_reset();
        wait_ce();
        wait_ce();
        reset_n = 1'b1;
        wait_ce();
        m_write(8'hA8, 8'h3C);
        chk("write_after_reset", slot1, 8'h3C);
        wait_ce();
        iorq_n = 1'b1;
        wr_n   = 1'b1;
        wait_ce();

        io_write(8'hAC, 8'hFF, 1, 1'b0);
        chk("unmatched_write", slot1, 8'h3C);
        io_read(8'hAC, 1, 1'b0, 8'h00, rd_first, rd_last);
        chk("unmatched_read", rd_first, 8'hFF);

        for (int i = 0; i < 200; i++) begin
            op = int'($urandom_range(0, 9));
            if ($urandom_range(0, 4) != 0) a = 8'hA8 + 8'($urandom_range(0, 3));
            else a = 8'($urandom);
            if (op <= 3) begin
                io_write(a, 8'($urandom), int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
            end else if (op <= 6) begin
                kb_col = 8'($urandom);
                io_read(a, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 8'($urandom),
                        rd_first, rd_last);
            end else if (op == 7) begin
                fetch();
            end else if (op == 8) begin
                inta(a, 8'($urandom), int'($urandom_range(0, 2)));
            end else begin
                wait_ce();
            end
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
